// File: rtl/_bus32_arb.sv
// Round-robin owner arbiter for the shared 32-bit tri-state bus.
// Grants one source at a time and inserts dead cycles between owners.
module _bus32_arb #(
  parameter int N        = 8,
  parameter int DEAD     = 1,
  parameter int MAX_HOLD = 0
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         g,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int  PW    = $clog2(N);
  localparam int  DW    = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam int  HW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit  FORCE = (MAX_HOLD > 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FORCE ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t          state, state_n;
  logic [N-1:0]    gnt_n;
  logic [PW-1:0]   owner_n, ptr, ptr_n;
  logic [HW-1:0]   hold, hold_n;
  logic [DW-1:0]   dead, dead_n;
  logic            timeout_n;

  logic            pick_vld;
  logic [PW-1:0]   pick, idx;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    ptr_n     = ptr;
    hold_n    = hold;
    dead_n    = dead;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          owner_n     = pick;
          ptr_n       = pick;
          hold_n      = '0;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        // Forced release wins even if the owner dropped its request this edge.
        if ((FORCE && hold == HOLD_LAST) || !req[owner]) begin
          gnt_n     = '0;
          owner_n   = '0;
          dead_n    = DW'(DEAD - 1);
          timeout_n = FORCE && (hold == HOLD_LAST);
          state_n   = TURN;
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      TURN: begin
        if (dead != '0) begin
          dead_n = dead - DW'(1);
        end else if (pick_vld) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          owner_n     = pick;
          ptr_n       = pick;
          hold_n      = '0;
          state_n     = GRANT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr     <= PW'(N - 1);
      hold    <= '0;
      dead    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      ptr     <= ptr_n;
      hold    <= hold_n;
      dead    <= dead_n;
      timeout <= timeout_n;
    end
  end

  assign g    = ~gnt;
  assign busy = |gnt;

endmodule

// File: doc/_bus32_arb.md
# _bus32_arb

Round-robin arbiter and drive-enable controller for the shared 32-bit tri-state bus built from 74x244 buffer groups. It accepts level requests from N bus sources and grants at most one owner at a time. It produces the active-low per-source output-enable vector that connects bit-for-bit to the bus's `g` input. Every change of owner is separated by break-before-make dead cycles, so two buffer groups never drive the bus together.

## Interface
- `N`, 8, number of bus sources; must match the bus instance's `N`; N ≥ 2.
- `DEAD`, 1, dead cycles with all enables high between one owner's release and the next grant; DEAD ≥ 1.
- `MAX_HOLD`, 0, maximum consecutive grant cycles before forced release; 0 = unlimited.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  level request per source; held high for as long as the source wants the bus.
- `gnt`  out  N  one-hot active-high grant, registered.
- `g`  out  N  active-low drive enables, always exactly `~gnt`; connects to the bus `g`.
- `owner`  out  clog2(N)  index of the current owner; valid only when `busy`=1, 0 otherwise.
- `busy`  out  1  high while any grant is active.
- `timeout`  out  1  one-cycle pulse when a MAX_HOLD forced release occurs.

## Operation
- Reset values: `gnt`=0, `g`=all ones, `owner`=0, `busy`=0, `timeout`=0, state IDLE, hold counter 0, round-robin pointer `ptr`=N-1.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If any `req` bit is set, pick the first set bit scanning upward from `(ptr+1) mod N` with wrap-around.
  - Load the winner into `gnt`/`owner`, set `ptr`=winner, and go to GRANT.
  - With no request, stay in IDLE.
- GRANT:
  - Stay while `req[owner]`=1.
  - Requests from other sources are ignored; there is no pre-emption.
  - The hold counter increments each GRANT cycle.
  - Normal release: `req[owner]`=0 at an edge clears `gnt`, loads the dead counter with DEAD-1, and moves to TURN.
  - Forced release: with MAX_HOLD>0 and the hold counter at MAX_HOLD-1, perform the same transition as a normal release and pulse `timeout` for one cycle, regardless of `req[owner]`.
- TURN:
  - `gnt`=0 throughout.
  - While the dead counter > 0, decrement it.
  - When it is 0, arbitrate exactly as in IDLE: grant directly if any `req` is set, otherwise go to IDLE.
- Fairness: after any release, including a forced one, the previous owner has lowest priority.
- A forced-release source that keeps `req` high is re-granted only when no other source requests, or when its turn comes around again.
- Invariant in every cycle, including reset: at most one bit of `gnt` is set, and `g` == `~gnt`.
- `rst` wins over every other event. At the edge where `rst`=1, all outputs take their reset values, whatever the state.

## Timing
- Grant latency: a `req` bit sampled high at edge k in IDLE gives `gnt` high after edge k (one registered stage). No combinational path runs from `req` to `gnt`/`g`.
- Release latency: `req[owner]` sampled low at edge k drops `gnt` after edge k.
- Gap: the earliest next grant is asserted after edge k+DEAD. This gives exactly DEAD cycles with `g` all ones.
- A requester whose `req` drops before it is granted loses its claim; nothing is latched.
- If the owner's `req` drops and another `req` rises at the same edge, the release happens first. The new request competes after the dead cycles.
- Hold length with MAX_HOLD=M: `gnt` stays high for exactly M cycles, and `timeout` is high during the first TURN cycle.
- `busy`, `owner` and `gnt` change on the same edges.

## Test plan
- Reset / idle:
  - Stimulus: assert `rst` mid-GRANT, with source 3 owning, N=8.
  - Required: `g`=8'hFF, `busy`=0 and `timeout`=0 after the reset edge.
  - Then, with `req`=8'h01 after reset, expect `gnt`=8'h01 one edge later.
- Round-robin:
  - Stimulus: hold `req`=8'hFF permanently, MAX_HOLD=2, DEAD=1.
  - Required: owners 0,1,2,…,7,0 in order; each grant lasts 2 cycles, then 1 dead cycle; `timeout` pulses once per grant.
- Break-before-make:
  - Stimulus: DEAD=3; source 2 owns; `req`=8'h24, then `req[2]` drops.
  - Required: exactly 3 cycles with `g`=8'hFF, then `gnt`=8'h20.
- No pre-emption:
  - Stimulus: source 5 owns; `req[0]` rises.
  - Required: `gnt` stays 8'h20 until `req[5]` falls.
- Wrap and fairness:
  - Stimulus: `ptr`=7 after source 7 releases; `req`=8'h81.
  - Required: source 0 is granted next, not 7.
- Invariant monitor: in every cycle of random `req`/`rst` stimulus (10k cycles), popcount(`gnt`) ≤ 1, `g`==~`gnt`, and every grant-to-grant transition has ≥ DEAD all-high cycles.
